alien_formation_ctrl: RTL

//  Sequential controller for the 9x4 alien formation; sits directly upstream of the alien colour

---
 rtl/alien_formation_ctrl_if.sv | 16 +
 rtl/alien_formation_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alien_formation_ctrl_if.sv
// ---------------------------------------------------------------------------
// alien_formation_ctrl_if
//   Shot-collision report channel between the collision detector (master)
//   and the formation controller (slave).
//   hit_valid : collision report strobe
//   hit_index : alien index 0..35 that was hit (9*row + col)
//   hit_ack   : one-clk pulse, the report cleared a live alien
// ---------------------------------------------------------------------------
interface alien_formation_ctrl_if;
    logic       hit_valid;
    logic [5:0] hit_index;
    logic       hit_ack;

    modport master (output hit_valid, output hit_index, input hit_ack);
    modport slave  (input hit_valid, input hit_index, output hit_ack);
endinterface

// File: rtl/alien_formation_ctrl.sv
// ---------------------------------------------------------------------------
// alien_formation_ctrl
//   Sequential controller for the 9x4 alien formation. Owns the formation
//   origin and the 36-bit alive mask, steps the block right/left on frame
//   ticks, drops it at the screen edges and clears aliens on shot hits.
//   Alien index = 9*row + col; cell 20x10 px, pitch 40x20 px.
//
//   Ports
//     clk, reset    : clock, synchronous active-high reset
//     tick          : one-clk frame pulse
//     new_wave      : one-clk pulse, reload formation (beats tick/hit)
//     hit           : slave side of the shot-hit channel (valid/index/ack)
//     xAlien/yAlien : formation origin
//     alive         : alive mask, bit 9*row+col
//     aliens_left   : popcount(alive)
//     step_pulse    : one-clk pulse after every move or drop
//     wave_cleared  : level, alive == 0
//     invaded       : level, sticky until reset/new_wave
//
//   Build option: define SPEEDUP_EN to make the step period shrink as
//   aliens die (MIN_TICKS + aliens_left/4); otherwise it is STEP_TICKS.
// ---------------------------------------------------------------------------
module alien_formation_ctrl #(
    parameter int X_START    = 20,
    parameter int Y_START    = 40,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int DX         = 4,
    parameter int DY         = 10,
    parameter int Y_INVADE   = 440,
    parameter int STEP_TICKS = 8,
    parameter int MIN_TICKS  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       new_wave,
    alien_formation_ctrl_if.slave      hit,
    output logic [9:0]                 xAlien,
    output logic [9:0]                 yAlien,
    output logic [35:0]                alive,
    output logic [5:0]                 aliens_left,
    output logic                       step_pulse,
    output logic                       wave_cleared,
    output logic                       invaded
);

    typedef enum logic [1:0] {MOVE_R, MOVE_L, CLEARED, INVADED} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n, period;
    logic [9:0]  x_n, y_n;
    logic [35:0] alive_n, hit_mask;
    logic [63:0] alive_pad;
    logic [8:0]  col_any;
    logic [3:0]  row_any;
    logic [3:0]  lc, rc;
    logic [1:0]  br;
    logic        hit_live, step_n;
    logic [5:0]  left_n;
    logic [10:0] reach_r, reach_l, x_up, bottom;

`ifdef SPEEDUP_EN
    assign period = 8'(MIN_TICKS) + {4'd0, aliens_left[5:2]};
`else
    assign period = (STEP_TICKS < MIN_TICKS) ? 8'(MIN_TICKS) : 8'(STEP_TICKS);
`endif

    always_comb begin
        // Edge columns come from the mask before this cycle's hit.
        col_any = '0;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 9; c++)
                if (alive[9*r + c]) col_any[c] = 1'b1;
        rc = '0;
        lc = '0;
        for (int unsigned c = 0; c < 9; c++)
            if (col_any[c]) rc = 4'(c);
        for (int unsigned c = 9; c > 0; c--)
            if (col_any[c-1]) lc = 4'(c - 1);

        // Padding lets out-of-range indices read as dead aliens.
        alive_pad = {28'd0, alive};
        hit_live  = hit.hit_valid && (hit.hit_index < 6'd36) && alive_pad[hit.hit_index];
        hit_mask  = 36'd1 << hit.hit_index;
        alive_n   = hit_live ? (alive & ~hit_mask) : alive;

        reach_r = 11'(xAlien) + 11'(rc) * 11'd40 + 11'd20 + 11'(DX);
        reach_l = 11'(xAlien) + 11'(lc) * 11'd40;
        x_up    = 11'(xAlien) + 11'(DX);

        state_n = state;
        x_n     = xAlien;
        y_n     = yAlien;
        cnt_n   = cnt;
        step_n  = 1'b0;

        if ((state == MOVE_R || state == MOVE_L) && tick) begin
            // >= keeps the counter safe if the period shrinks between steps.
            if (cnt >= period - 8'd1) begin
                cnt_n  = '0;
                step_n = 1'b1;
                if (state == MOVE_R) begin
                    if (reach_r <= 11'(X_MAX)) begin
                        x_n = (x_up > 11'd1023) ? 10'd1023 : x_up[9:0];
                    end else begin
                        y_n     = yAlien + 10'(DY);
                        state_n = MOVE_L;
                    end
                end else begin
                    if (reach_l >= 11'(X_MIN) + 11'(DX)) begin
                        // A dead left column can let the origin go negative; pin at 0.
                        x_n = (xAlien < 10'(DX)) ? '0 : xAlien - 10'(DX);
                    end else begin
                        y_n     = yAlien + 10'(DY);
                        state_n = MOVE_R;
                    end
                end
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end

        // Bottom row and population come from the post-hit mask.
        for (int unsigned r = 0; r < 4; r++)
            row_any[r] = |alive_n[9*r +: 9];
        br = '0;
        for (int unsigned r = 0; r < 4; r++)
            if (row_any[r]) br = 2'(r);
        bottom = 11'(y_n) + 11'(br) * 11'd20 + 11'd10;

        left_n = '0;
        for (int unsigned i = 0; i < 36; i++)
            if (alive_n[i]) left_n = left_n + 6'd1;

        // Terminal states only entered from the moving states; once there,
        // hits still clear bits but nothing moves.
        if (state == MOVE_R || state == MOVE_L) begin
            if (alive_n == '0)
                state_n = CLEARED;
            else if (bottom >= 11'(Y_INVADE))
                state_n = INVADED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || new_wave) begin
            state        <= MOVE_R;
            cnt          <= '0;
            xAlien       <= 10'(X_START);
            yAlien       <= 10'(Y_START);
            alive        <= '1;
            aliens_left  <= 6'd36;
            hit.hit_ack  <= 1'b0;
            step_pulse   <= 1'b0;
            wave_cleared <= 1'b0;
            invaded      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            xAlien       <= x_n;
            yAlien       <= y_n;
            alive        <= alive_n;
            aliens_left  <= left_n;
            hit.hit_ack  <= hit_live;
            step_pulse   <= step_n;
            wave_cleared <= (alive_n == '0);
            invaded      <= (state_n == INVADED);
        end
    end

endmodule
